// File: rtl/mkg_round_sequencer.sv
// Iterative keyed MKG round engine: accepts seed/keys/round count, applies one
// MKG round per cycle, then holds the final state and parity until consumed.

// Combinational MKG reversible gate, {A,B,C,D} -> {P,Q,R,S}.
module MKG_gate (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_d,
  output logic o_p,
  output logic o_q,
  output logic o_r,
  output logic o_s
);
  logic w_t;

  // Shared term ((~A & ~D) ^ ~B) feeds both R and S.
  assign w_t = (~i_a & ~i_d) ^ ~i_b;
  assign o_p = i_a;
  assign o_q = i_c;
  assign o_r = w_t ^ i_c;
  assign o_s = (w_t & i_c) ^ ((i_a & i_b) ^ i_d);
endmodule

module mkg_round_sequencer #(
  parameter int unsigned NR = 8,
  parameter int unsigned RW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_seed,
  input  logic [4*NR-1:0] in_chal,
  input  logic [RW-1:0]   in_rounds,
  input  logic            abort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_resp,
  output logic            out_parity,
  output logic            busy,
  output logic [RW-1:0]   round_idx
);
  localparam int unsigned KIW = (NR > 1) ? $clog2(NR) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t                 r_fsm, w_fsm_nxt;
  logic [3:0]           r_state, w_state_nxt;
  logic [NR-1:0][3:0]   r_keys, w_keys_nxt;
  logic [RW-1:0]        r_reff, w_reff_nxt;
  logic [RW-1:0]        r_cnt, w_cnt_nxt;
  logic                 r_in_ready, r_out_valid, r_busy, r_parity;

  logic [RW-1:0]        w_reff_in;
  logic [KIW-1:0]       w_kidx;
  logic [3:0]           w_key;
  logic [3:0]           w_mix;
  logic [3:0]           w_mkg;

  // Round count saturates at NR.
  assign w_reff_in = (in_rounds > RW'(NR)) ? RW'(NR) : in_rounds;

  // Key for the round applied on the coming edge.
  assign w_kidx = r_cnt[KIW-1:0];
  assign w_key  = r_keys[w_kidx];
  assign w_mix  = r_state ^ w_key;

  MKG_gate u_mkg (
    .i_a (w_mix[3]),
    .i_b (w_mix[2]),
    .i_c (w_mix[1]),
    .i_d (w_mix[0]),
    .o_p (w_mkg[3]),
    .o_q (w_mkg[2]),
    .o_r (w_mkg[1]),
    .o_s (w_mkg[0])
  );

  // Next-state and datapath update; cnt returns to 0 whenever RUN is left.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_keys_nxt  = r_keys;
    w_reff_nxt  = r_reff;
    w_cnt_nxt   = r_cnt;
    case (r_fsm)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = in_seed;
          w_keys_nxt  = in_chal;
          w_reff_nxt  = w_reff_in;
          w_cnt_nxt   = '0;
          w_fsm_nxt   = (w_reff_in != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          w_fsm_nxt = IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_state_nxt = w_mkg;
          if (r_cnt == (r_reff - RW'(1))) begin
            w_fsm_nxt = DONE;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + RW'(1);
          end
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          w_fsm_nxt = IDLE;
        end
      end
      default: begin
        w_fsm_nxt = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_state     <= '0;
      r_keys      <= '0;
      r_reff      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_parity    <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_state     <= w_state_nxt;
      r_keys      <= w_keys_nxt;
      r_reff      <= w_reff_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_fsm_nxt == IDLE);
      r_out_valid <= (w_fsm_nxt == DONE);
      r_busy      <= (w_fsm_nxt == RUN);
      r_parity    <= ^w_state_nxt;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign out_resp   = r_state;
  assign out_parity = r_parity;
  assign round_idx  = r_cnt;
endmodule
